div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: MIN_WAIT, default 16, WAIT cycles before div_valid is honoured; TIMEOUT, default 24, WAIT cycle at which capture is forced.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  operand pair offered.
REQ-005 op_ready  out  1  sequencer can accept an operand pair.
REQ-006 op_dividend  in  8  unsigned dividend.
REQ-007 op_divisor  in  7  unsigned divisor.
REQ-008 div_start  out  1  one-cycle start pulse to divider.
REQ-009 div_dividend  out  8  dividend driven to the divider's dividendin.
REQ-010 div_divisor  out  7  divisor driven to the divider's divisorin.
REQ-011 div_quotient  in  8  divider quotient.
REQ-012 div_remainder  in  7  divider remainder.
REQ-013 div_valid  in  1  divider result valid.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  consumer takes result.
REQ-016 res_quotient  out  8  captured quotient.
REQ-017 res_remainder  out  7  captured remainder.
REQ-018 res_divzero  out  1  divisor was zero; divider not started.
REQ-019 res_timeout  out  1  capture forced at TIMEOUT without div_valid.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-021 op_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with op_valid&op_ready.
REQ-022 On transfer, operands SHALL be registered into div_dividend/div_divisor and held stable until the next transfer.
REQ-023 Transfer with divisor!=0 SHALL go IDLE->START; div_start SHALL be 1 for exactly the one START cycle, then go to WAIT.
REQ-024 Transfer with divisor==0 SHALL go IDLE->DONE directly with res_quotient=8'hFF, res_remainder=0, res_divzero=1, and no div_start pulse.
REQ-025 A 5-bit wait counter SHALL be 0 in the first WAIT cycle and increment each WAIT cycle.
REQ-026 div_valid SHALL be ignored while counter<MIN_WAIT.
REQ-027 In WAIT, with div_valid=1 and counter>=MIN_WAIT, the block SHALL capture div_quotient/div_remainder, set res_timeout=0, and go to DONE.
REQ-028 In WAIT, with counter==TIMEOUT and no qualifying div_valid, the block SHALL capture the divider outputs anyway, set res_timeout=1, and go to DONE.
REQ-029 Nominal latency SHALL be: transfer at edge T0, div_start high T0..T1, capture at edge T0+1+MIN_WAIT+1 (T18 by default), res_valid high from that edge.
REQ-030 In DONE, res_valid SHALL be 1 and the res_* outputs SHALL be stable until res_valid&res_ready; on that edge the block SHALL return to IDLE.
REQ-031 op_ready SHALL become 1 in the cycle after the result handshake; there SHALL be no back-to-back acceptance with DONE.
REQ-032 op_valid SHALL be ignored outside IDLE; res_ready SHALL be ignored outside DONE.

Reset
REQ-033 Reset SHALL force IDLE and counter 0, and clear all outputs to 0 (op_ready becomes 1 in the first cycle after reset).
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no res_valid, and the stale divider result SHALL never be presented.

Structure
REQ-035 A shared package div_pkg SHALL hold the widths (DIVIDEND_W=8, DIVISOR_W=7), the state enum, and the MIN_WAIT/TIMEOUT defaults.
REQ-036 The block SHALL be one module; the divider is instantiated beside it, not inside it.

Verification
REQ-037 Nominal divide: op 200/7 with a divider model returning valid at WAIT count 16 -> single div_start pulse, res 28 rem 4 at T18, res_timeout=0.
REQ-038 Divide by zero: op 55/0 -> no div_start, res_valid the next cycle, quotient=255, remainder=0, res_divzero=1.
REQ-039 Early spurious valid: div_valid pulsed at WAIT count 3 -> ignored; capture still occurs at count 16.
REQ-040 Timeout: div_valid held at 0 -> capture at WAIT count 24 with res_timeout=1.
REQ-041 Backpressure: res_ready held low 10 cycles, op_valid high throughout -> outputs stable, op_ready=0, next op accepted one cycle after the handshake.
REQ-042 Reset during WAIT (count 8) -> IDLE next cycle, outputs 0, no res_valid; a following op 255/1 -> 255 rem 0.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared widths, FSM state encoding and timing defaults for the divider
// sequencer and its bus interface.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 7;

  // Wait counter must be able to reach TIMEOUT.
  localparam int CNT_W = 5;

  localparam int MIN_WAIT_DEF = 16;
  localparam int TIMEOUT_DEF  = 24;

  // Result reported when the divisor is zero and the divider is skipped.
  localparam logic [DIVIDEND_W-1:0] DIVZERO_QUOTIENT  = '1;
  localparam logic [DIVISOR_W-1:0]  DIVZERO_REMAINDER = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // True when a cycle count can be represented by the wait counter.
  function automatic bit fits_cnt(input int value);
    return (value >= 0) && (value < (1 << CNT_W));
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Bundles the three handshakes of the divider sequencer:
//   op_*  : operand pair offered by the producer (valid/ready)
//   div_* : start pulse and operands to the external divider, result back
//   res_* : captured result to the consumer (valid/ready)
// Modports:
//   slave  : the sequencer itself
//   master : the surrounding logic (producer, divider, consumer)
// -----------------------------------------------------------------------------
interface div_sequencer_if;
  import div_pkg::*;

  logic                  op_valid;
  logic                  op_ready;
  logic [DIVIDEND_W-1:0] op_dividend;
  logic [DIVISOR_W-1:0]  op_divisor;

  logic                  div_start;
  logic [DIVIDEND_W-1:0] div_dividend;
  logic [DIVISOR_W-1:0]  div_divisor;
  logic [DIVIDEND_W-1:0] div_quotient;
  logic [DIVISOR_W-1:0]  div_remainder;
  logic                  div_valid;

  logic                  res_valid;
  logic                  res_ready;
  logic [DIVIDEND_W-1:0] res_quotient;
  logic [DIVISOR_W-1:0]  res_remainder;
  logic                  res_divzero;
  logic                  res_timeout;

  modport slave (
    input  op_valid, op_dividend, op_divisor,
    input  div_quotient, div_remainder, div_valid,
    input  res_ready,
    output op_ready,
    output div_start, div_dividend, div_divisor,
    output res_valid, res_quotient, res_remainder, res_divzero, res_timeout
  );

  modport master (
    output op_valid, op_dividend, op_divisor,
    output div_quotient, div_remainder, div_valid,
    output res_ready,
    input  op_ready,
    input  div_start, div_dividend, div_divisor,
    input  res_valid, res_quotient, res_remainder, res_divzero, res_timeout
  );

endinterface

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Accepts one operand pair, launches the external divider with a one-cycle
// start pulse, waits a minimum number of cycles before trusting div_valid,
// forces a capture at TIMEOUT if the divider never answers, and holds the
// result until the consumer takes it. A zero divisor bypasses the divider.
//
// Parameters:
//   MIN_WAIT : WAIT cycles before div_valid is honoured
//   TIMEOUT  : WAIT cycle count at which capture is forced
// Ports:
//   clk   : clock, all logic on rising edge
//   reset : synchronous active-high reset
//   bus   : div_sequencer_if.slave (op_*, div_*, res_* handshakes)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | op_ready high, waiting for an operand pair
// START | div_start high for this single cycle
// WAIT  | counting cycles, qualifying div_valid, watching for TIMEOUT
// DONE  | res_valid high, result held until res_ready
// -----------------------------------------------------------------------------
module div_sequencer
  import div_pkg::*;
#(
  parameter int MIN_WAIT = MIN_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  div_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  div_state_t            state;
  div_state_t            state_nxt;

  logic [CNT_W-1:0]      wait_cnt;

  logic [DIVIDEND_W-1:0] dividend_q;
  logic [DIVISOR_W-1:0]  divisor_q;

  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  divzero_q;
  logic                  timeout_q;

  logic                  load_ops;
  logic                  cap_zero;
  logic                  cap_div;
  logic                  cap_timeout;
  logic                  div_ok;

  // div_valid only counts once the minimum wait has elapsed; earlier pulses
  // are treated as glitches from a divider that has not settled.
  assign div_ok = bus.div_valid && (wait_cnt >= MIN_WAIT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_ops    = 1'b0;
    cap_zero    = 1'b0;
    cap_div     = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          load_ops = 1'b1;
          if (bus.op_divisor == '0) begin
            cap_zero  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = START;
          end
        end
      end
      START: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_ok) begin
          cap_div   = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == TIMEOUT_C) begin
          // Take whatever the divider is driving and flag it as untrusted.
          cap_div     = 1'b1;
          cap_timeout = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counter is zero on entry to WAIT because it is held clear elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Operands stay on the divider inputs until the next accepted pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (load_ops) begin
      dividend_q <= bus.op_dividend;
      divisor_q  <= bus.op_divisor;
    end
  end

  // Result registers are cleared by reset so an abandoned divide can never
  // leak its result onto res_* later.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (cap_zero) begin
      quotient_q  <= DIVZERO_QUOTIENT;
      remainder_q <= DIVZERO_REMAINDER;
      divzero_q   <= 1'b1;
      timeout_q   <= 1'b0;
    end else if (cap_div) begin
      quotient_q  <= bus.div_quotient;
      remainder_q <= bus.div_remainder;
      divzero_q   <= 1'b0;
      timeout_q   <= cap_timeout;
    end
  end

  // op_ready is masked by reset so that every output reads 0 while reset is
  // held; it rises in the first cycle after reset is released.
  assign bus.op_ready      = (state == IDLE) && !reset;
  assign bus.div_start     = (state == START);
  assign bus.res_valid     = (state == DONE);

  assign bus.div_dividend  = dividend_q;
  assign bus.div_divisor   = divisor_q;

  assign bus.res_quotient  = quotient_q;
  assign bus.res_remainder = remainder_q;
  assign bus.res_divzero   = divzero_q;
  assign bus.res_timeout   = timeout_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  import div_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_sequencer_if bus();

  div_sequencer #(.MIN_WAIT(16), .TIMEOUT(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int starts   = 0;
  int t0       = 0;
  int s0       = 0;

  // Divider model: cycle count aligned with the sequencer's WAIT count.
  int   valid_at = 16;
  int   spur_at  = -1;
  int   mcnt     = 0;
  logic busy     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.div_start) starts <= starts + 1;

  always @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      mcnt <= 0;
    end else if (bus.div_start) begin
      busy <= 1'b1;
      mcnt <= 0;
    end else if (busy) begin
      mcnt <= mcnt + 1;
    end
  end

  assign bus.div_valid     = busy && ((mcnt == valid_at) || (mcnt == spur_at));
  assign bus.div_quotient  = (bus.div_divisor != '0) ?
                             8'(bus.div_dividend / {1'b0, bus.div_divisor}) : 8'hFF;
  assign bus.div_remainder = (bus.div_divisor != '0) ?
                             7'(bus.div_dividend % {1'b0, bus.div_divisor}) : 7'd0;

  typedef struct {
    logic [7:0] q;
    logic [6:0] r;
    logic       dz;
    logic       to;
    int         lat;
    int         nstart;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] q, input logic [6:0] r, input logic dz,
                      input logic to, input int lat, input int nstart);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.to = to; e.lat = lat; e.nstart = nstart;
    sb.push_back(e);
  endtask

  task automatic send_op(input logic [7:0] a, input logic [6:0] b);
    @(negedge clk);
    bus.op_valid    = 1'b1;
    bus.op_dividend = a;
    bus.op_divisor  = b;
    check("op_ready_idle", bus.op_ready, 1);
    @(posedge clk);
    #1;
    t0 = cyc;
    s0 = starts;
    bus.op_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    exp_t e;
    int n;
    n = 0;
    e = sb.pop_front();
    while (bus.res_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, bus.res_valid, 1);
    check({tag, "_latency"},   cyc - t0,      e.lat);
    check({tag, "_quotient"},  bus.res_quotient,  e.q);
    check({tag, "_remainder"}, bus.res_remainder, e.r);
    check({tag, "_divzero"},   bus.res_divzero,   e.dz);
    check({tag, "_timeout"},   bus.res_timeout,   e.to);
    check({tag, "_starts"},    starts - s0,       e.nstart);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check({tag, "_hs_op_ready"},  bus.op_ready,  1);
    check({tag, "_hs_res_valid"}, bus.res_valid, 0);
  endtask

  initial begin
    logic seen_valid;
    bus.op_valid    = 1'b0;
    bus.op_dividend = '0;
    bus.op_divisor  = '0;
    bus.res_ready   = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_op_ready",     bus.op_ready,     0);
    check("rst_div_start",    bus.div_start,    0);
    check("rst_res_valid",    bus.res_valid,    0);
    check("rst_div_dividend", bus.div_dividend, 0);
    check("rst_div_divisor",  bus.div_divisor,  0);
    check("rst_res_quotient", bus.res_quotient, 0);
    check("rst_res_divzero",  bus.res_divzero,  0);
    check("rst_res_timeout",  bus.res_timeout,  0);
    reset = 1'b0;
    #1;
    check("rst_release_op_ready", bus.op_ready, 1);

    // Nominal 200/7
    push(8'd28, 7'd4, 1'b0, 1'b0, 18, 1);
    send_op(8'd200, 7'd7);
    check("nom_op_ready_busy", bus.op_ready, 0);
    check("nom_div_dividend",  bus.div_dividend, 200);
    check("nom_div_divisor",   bus.div_divisor,  7);
    get_result("nominal");
    handshake("nominal");

    // Divide by zero 55/0
    push(8'd255, 7'd0, 1'b1, 1'b0, 0, 0);
    send_op(8'd55, 7'd0);
    get_result("divzero");
    handshake("divzero");

    // Early spurious valid at WAIT count 3
    spur_at = 3;
    push(8'd11, 7'd1, 1'b0, 1'b0, 18, 1);
    send_op(8'd100, 7'd9);
    get_result("spurious");
    handshake("spurious");
    spur_at = -1;

    // Timeout: divider never answers
    valid_at = 1000;
    push(8'd15, 7'd2, 1'b0, 1'b1, 26, 1);
    send_op(8'd77, 7'd5);
    get_result("timeout");
    handshake("timeout");
    valid_at = 16;

    // Backpressure with next operand already offered
    push(8'd22, 7'd2, 1'b0, 1'b0, 18, 1);
    send_op(8'd90, 7'd4);
    get_result("bp_first");
    bus.op_valid    = 1'b1;
    bus.op_dividend = 8'd60;
    bus.op_divisor  = 7'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid",    bus.res_valid,     1);
      check("bp_op_ready",     bus.op_ready,      0);
      check("bp_quotient",     bus.res_quotient,  22);
      check("bp_remainder",    bus.res_remainder, 2);
      check("bp_div_dividend", bus.div_dividend,  90);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("bp_hs_op_ready",  bus.op_ready,  1);
    check("bp_hs_res_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    t0 = cyc;
    s0 = starts;
    bus.op_valid = 1'b0;
    check("bp_next_accepted",  bus.op_ready,     0);
    check("bp_next_div_start", bus.div_start,    1);
    check("bp_next_dividend",  bus.div_dividend, 60);
    push(8'd10, 7'd0, 1'b0, 1'b0, 18, 1);
    get_result("bp_second");
    handshake("bp_second");

    // Reset during WAIT at count 8
    send_op(8'd150, 7'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_res_valid",    bus.res_valid,     0);
    check("mid_rst_div_start",    bus.div_start,     0);
    check("mid_rst_op_ready",     bus.op_ready,      0);
    check("mid_rst_div_dividend", bus.div_dividend,  0);
    check("mid_rst_res_quotient", bus.res_quotient,  0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_release_op_ready", bus.op_ready, 1);
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    end
    check("mid_rst_no_res_valid", seen_valid, 0);
    push(8'd255, 7'd0, 1'b0, 1'b0, 18, 1);
    send_op(8'd255, 7'd1);
    get_result("after_rst");
    handshake("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
